// File: rtl/dvi_lvds_pkg.sv
// Shared constants and helpers for the DVI-to-LVDS pixel converter:
// reduction modes, the 2x2 Bayer table and the dither threshold.
package dvi_lvds_pkg;

    localparam int DITHER_TRUNC   = 0;
    localparam int DITHER_ROUND   = 1;
    localparam int DITHER_ORDERED = 2;

    // Widest threshold is 3 << 2 = 12, so four bits are enough.
    localparam int THR_W = 4;

    function automatic int reduce_bits(input int in_w, input int out_w);
        return in_w - out_w;
    endfunction

    function automatic bit reduce_bits_legal(input int d);
        return (d >= 0) && (d <= 4);
    endfunction

    function automatic logic [1:0] bayer(input logic [1:0] idx);
        logic [1:0] b;
        case (idx)
            2'd0:    b = 2'd0;
            2'd1:    b = 2'd2;
            2'd2:    b = 2'd3;
            2'd3:    b = 2'd1;
            default: b = 2'd0;
        endcase
        return b;
    endfunction

    // Value added before the right shift by d; ordered dither needs d >= 2.
    function automatic logic [THR_W-1:0] dither_thr(input int mode, input int d,
                                                    input logic [1:0] idx);
        logic [THR_W-1:0] thr;
        if (d <= 0) begin
            thr = 4'd0;
        end else if (mode == DITHER_TRUNC) begin
            thr = 4'd0;
        end else if ((mode == DITHER_ORDERED) && (d >= 2)) begin
            thr = {2'b00, bayer(idx)} << (d - 2);
        end else begin
            thr = 4'd1 << (d - 1);
        end
        return thr;
    endfunction

endpackage

// File: rtl/dvi_lvds_pixconv_lane.sv
// One colour channel: optional inversion (stage 1), threshold add,
// shift and saturation, then the blanked stage-2 output register.
module pixconv_lane
    import dvi_lvds_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 6,
    parameter int INVERT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  i_pix,
    input  logic [THR_W-1:0] i_thr,
    input  logic             i_de,
    output logic [OUT_W-1:0] o_pix
);

    localparam int D = reduce_bits(IN_W, OUT_W);
    localparam logic [IN_W:0] MAX_OUT = (IN_W + 1)'((1 << OUT_W) - 1);

    logic [IN_W-1:0]  r_v;
    logic [IN_W:0]    w_thr;
    logic [IN_W:0]    w_sum;
    logic [IN_W:0]    w_shift;
    logic [OUT_W-1:0] w_red;

    // The extra top bit of the sum catches the carry that must saturate.
    assign w_thr   = (IN_W + 1)'(i_thr);
    assign w_sum   = {1'b0, r_v} + w_thr;
    assign w_shift = w_sum >> D;

    // Clamp the reduced value to the largest OUT_W code.
    always_comb begin
        w_red = '0;
        if (w_shift > MAX_OUT) begin
            w_red = MAX_OUT[OUT_W-1:0];
        end else begin
            w_red = w_shift[OUT_W-1:0];
        end
    end

    // Stage 1 holds the inverted pixel, stage 2 the reduced and blanked one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v   <= '0;
            o_pix <= '0;
        end else begin
            r_v   <= (INVERT != 0) ? ~i_pix : i_pix;
            o_pix <= i_de ? w_red : '0;
        end
    end

endmodule

// File: rtl/dvi_lvds_pixconv.sv
// DVI decoder to LVDS encoder pixel converter: colour reduction with a
// 2-clock matched sync/DE path and per-frame active-resolution measurement.
module dvi_lvds_pixconv
    import dvi_lvds_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int OUT_W       = 6,
    parameter int INVERT      = 0,
    parameter int DITHER_MODE = 0,
    parameter int CNT_W       = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             de_in,
    input  logic [IN_W-1:0]  red_in,
    input  logic [IN_W-1:0]  green_in,
    input  logic [IN_W-1:0]  blue_in,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [OUT_W-1:0] red,
    output logic [OUT_W-1:0] green,
    output logic [OUT_W-1:0] blue,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_active,
    output logic             meas_valid
);

    localparam int D = reduce_bits(IN_W, OUT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    generate
        if (!reduce_bits_legal(D)) begin : g_bad_width
            $error("dvi_lvds_pixconv: IN_W - OUT_W must be in 0..4");
        end
    endgenerate

    logic             r_de_d;
    logic             r_vs_d;
    logic [CNT_W-1:0] r_x_cnt;
    logic [CNT_W-1:0] r_y_cnt;
    logic [1:0]       r_frame;
    logic [CNT_W-1:0] r_line_len;
    logic             r_vs_seen;
    logic             r_hs1;
    logic             r_vs1;
    logic             r_de1;
    logic [THR_W-1:0] r_thr1;

    logic             w_de_fall;
    logic             w_vs_rise;
    logic [1:0]       w_idx;
    logic [THR_W-1:0] w_thr;
    logic [CNT_W-1:0] w_y_next;

    assign w_de_fall = r_de_d & ~de_in;
    assign w_vs_rise = vsync_in & ~r_vs_d;
    assign w_idx     = {r_y_cnt[0] ^ r_frame[1], r_x_cnt[0] ^ r_frame[0]};
    assign w_thr     = dither_thr(DITHER_MODE, D, w_idx);
    assign w_y_next  = (r_y_cnt != CNT_MAX) ? r_y_cnt + 1'b1 : r_y_cnt;

    // Edge-detect copies, saturating position counters and frame phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_de_d     <= 1'b0;
            r_vs_d     <= 1'b0;
            r_x_cnt    <= '0;
            r_y_cnt    <= '0;
            r_frame    <= 2'd0;
            r_line_len <= '0;
        end else begin
            r_de_d <= de_in;
            r_vs_d <= vsync_in;
            if (de_in) begin
                if (r_x_cnt != CNT_MAX) begin
                    r_x_cnt <= r_x_cnt + 1'b1;
                end
            end else if (w_de_fall) begin
                r_x_cnt <= '0;
            end
            // x_cnt at the falling edge already equals last pixel index + 1.
            if (w_de_fall) begin
                r_line_len <= r_x_cnt;
            end
            if (w_vs_rise) begin
                r_y_cnt <= '0;
                r_frame <= r_frame + 2'd1;
            end else if (w_de_fall) begin
                r_y_cnt <= w_y_next;
            end
        end
    end

    // Frame measurement; the first frame after reset is partial, so the
    // result is flagged valid only from the second vsync rise onwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_active   <= '0;
            v_active   <= '0;
            r_vs_seen  <= 1'b0;
            meas_valid <= 1'b0;
        end else if (w_vs_rise) begin
            h_active   <= r_line_len;
            v_active   <= w_de_fall ? w_y_next : r_y_cnt;
            r_vs_seen  <= 1'b1;
            meas_valid <= meas_valid | r_vs_seen;
        end
    end

    // Sync, DE and threshold delay line matching the colour lanes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs1  <= 1'b0;
            r_vs1  <= 1'b0;
            r_de1  <= 1'b0;
            r_thr1 <= '0;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            de     <= 1'b0;
        end else begin
            r_hs1  <= hsync_in;
            r_vs1  <= vsync_in;
            r_de1  <= de_in;
            r_thr1 <= w_thr;
            hsync  <= r_hs1;
            vsync  <= r_vs1;
            de     <= r_de1;
        end
    end

    pixconv_lane #(.IN_W(IN_W), .OUT_W(OUT_W), .INVERT(INVERT)) u_red (
        .clk(clk), .reset(reset), .i_pix(red_in), .i_thr(r_thr1), .i_de(r_de1), .o_pix(red)
    );

    pixconv_lane #(.IN_W(IN_W), .OUT_W(OUT_W), .INVERT(INVERT)) u_green (
        .clk(clk), .reset(reset), .i_pix(green_in), .i_thr(r_thr1), .i_de(r_de1), .o_pix(green)
    );

    pixconv_lane #(.IN_W(IN_W), .OUT_W(OUT_W), .INVERT(INVERT)) u_blue (
        .clk(clk), .reset(reset), .i_pix(blue_in), .i_thr(r_thr1), .i_de(r_de1), .o_pix(blue)
    );

endmodule

// File: tb/tb_dvi_lvds_pixconv.sv
// Directed bench: four converter instances (truncate, inverted truncate,
// round, ordered dither) share one stimulus stream.
module tb_dvi_lvds_pixconv;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync_in, vsync_in, de_in;
    logic [7:0] red_in, green_in, blue_in;

    logic       m0_hs, m0_vs, m0_de, m0_mv;
    logic [5:0] m0_r, m0_g, m0_b;
    logic [11:0] m0_h, m0_v;
    logic       iv_hs, iv_vs, iv_de, iv_mv;
    logic [5:0] iv_r, iv_g, iv_b;
    logic [11:0] iv_h, iv_v;
    logic       rn_hs, rn_vs, rn_de, rn_mv;
    logic [5:0] rn_r, rn_g, rn_b;
    logic [11:0] rn_h, rn_v;
    logic       dt_hs, dt_vs, dt_de, dt_mv;
    logic [5:0] dt_r, dt_g, dt_b;
    logic [11:0] dt_h, dt_v;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dvi_lvds_pixconv #(.IN_W(8), .OUT_W(6), .INVERT(0), .DITHER_MODE(0), .CNT_W(12)) u_m0 (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hsync(m0_hs), .vsync(m0_vs), .de(m0_de), .red(m0_r), .green(m0_g), .blue(m0_b),
        .h_active(m0_h), .v_active(m0_v), .meas_valid(m0_mv));

    dvi_lvds_pixconv #(.IN_W(8), .OUT_W(6), .INVERT(1), .DITHER_MODE(0), .CNT_W(12)) u_inv (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hsync(iv_hs), .vsync(iv_vs), .de(iv_de), .red(iv_r), .green(iv_g), .blue(iv_b),
        .h_active(iv_h), .v_active(iv_v), .meas_valid(iv_mv));

    dvi_lvds_pixconv #(.IN_W(8), .OUT_W(6), .INVERT(0), .DITHER_MODE(1), .CNT_W(12)) u_rnd (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hsync(rn_hs), .vsync(rn_vs), .de(rn_de), .red(rn_r), .green(rn_g), .blue(rn_b),
        .h_active(rn_h), .v_active(rn_v), .meas_valid(rn_mv));

    dvi_lvds_pixconv #(.IN_W(8), .OUT_W(6), .INVERT(0), .DITHER_MODE(2), .CNT_W(12)) u_dit (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hsync(dt_hs), .vsync(dt_vs), .de(dt_de), .red(dt_r), .green(dt_g), .blue(dt_b),
        .h_active(dt_h), .v_active(dt_v), .meas_valid(dt_mv));

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] pix;
        logic [5:0] e_m0;
        logic [5:0] e_inv;
        logic [5:0] e_rnd;
    } vec_t;

    vec_t vecs [11];
    logic [5:0] d_prev;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One dither step: output now reflects the pixel of the previous step.
    task automatic dstep(input logic de_v, input logic vs_v, input logic [7:0] pix,
                         input logic [5:0] exp_this);
        de_in = de_v; vsync_in = vs_v;
        red_in = pix; green_in = pix; blue_in = pix;
        tick();
        check("dither_rgb", {dt_r, dt_g, dt_b}, {d_prev, d_prev, d_prev});
        d_prev = exp_this;
    endtask

    task automatic do_line(input int n, input logic vs_at_end);
        de_in = 1'b1;
        repeat (n) tick();
        de_in = 1'b0;
        vsync_in = vs_at_end;
        tick();
        vsync_in = 1'b0;
    endtask

    task automatic do_vsync();
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
    endtask

    task automatic do_frame(input int lines, input int len, input int last_len,
                            input logic vs_end);
        for (int l = 0; l < lines - 1; l++) do_line(len, 1'b0);
        do_line(last_len, vs_end);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'hB7, 6'h2D, 6'h12, 6'h2E};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 6'h00, 6'h3F, 6'h00};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 6'h3F, 6'h00, 6'h3F};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h80, 6'h20, 6'h1F, 6'h20};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h02, 6'h00, 6'h3F, 6'h01};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h01, 6'h00, 6'h3F, 6'h00};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'hFE, 6'h3F, 6'h00, 6'h3F};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'hB7, 6'h00, 6'h00, 6'h00};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h41, 6'h10, 6'h2F, 6'h10};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h7F, 6'h1F, 6'h20, 6'h20};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'hFF, 6'h00, 6'h00, 6'h00};

        reset = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0;
        red_in = 8'h00; green_in = 8'h00; blue_in = 8'h00;
        repeat (3) tick();
        check("reset_outputs",
              {m0_hs, m0_vs, m0_de, m0_r, m0_g, m0_b, m0_h, m0_v, m0_mv}, 64'd0);
        check("reset_inv_colour", {iv_r, iv_g, iv_b}, 64'd0);
        reset = 1'b0;
        tick();

        // Table: each vector held 2 clocks; output changes only on the 2nd.
        begin
            logic [5:0] prev_r;
            logic       prev_hs;
            prev_r = 6'h00;
            prev_hs = 1'b0;
            for (int i = 0; i < 11; i++) begin
                de_in = vecs[i].de; hsync_in = vecs[i].hs; vsync_in = vecs[i].vs;
                red_in = vecs[i].pix; green_in = vecs[i].pix; blue_in = vecs[i].pix;
                tick();
                check("latency_red", m0_r, prev_r);
                check("latency_hsync", m0_hs, prev_hs);
                tick();
                check("trunc_rgb", {m0_r, m0_g, m0_b}, {vecs[i].e_m0, vecs[i].e_m0, vecs[i].e_m0});
                check("invert_rgb", {iv_r, iv_g, iv_b}, {vecs[i].e_inv, vecs[i].e_inv, vecs[i].e_inv});
                check("round_rgb", {rn_r, rn_g, rn_b}, {vecs[i].e_rnd, vecs[i].e_rnd, vecs[i].e_rnd});
                check("sync_de", {m0_hs, m0_vs, m0_de}, {vecs[i].hs, vecs[i].vs, vecs[i].de});
                prev_r = vecs[i].e_m0;
                prev_hs = vecs[i].hs;
            end
        end
        hsync_in = 1'b0; vsync_in = 1'b0;

        // Distinct colours per lane.
        de_in = 1'b1; red_in = 8'hB7; green_in = 8'h40; blue_in = 8'h03;
        tick(); tick();
        check("lanes_trunc", {m0_r, m0_g, m0_b}, {6'h2D, 6'h10, 6'h00});
        check("lanes_invert", {iv_r, iv_g, iv_b}, {6'h12, 6'h2F, 6'h3F});
        check("lanes_round", {rn_r, rn_g, rn_b}, {6'h2E, 6'h10, 6'h01});
        de_in = 1'b0;
        tick(); tick();

        // Ordered dither over a 2x2 block in frame 0, then frame 1.
        pulse_reset();
        d_prev = 6'h00;
        dstep(1'b1, 1'b0, 8'h41, 6'h10);
        dstep(1'b1, 1'b0, 8'h41, 6'h10);
        dstep(1'b0, 1'b0, 8'h41, 6'h00);
        dstep(1'b1, 1'b0, 8'h41, 6'h11);
        dstep(1'b1, 1'b0, 8'h41, 6'h10);
        dstep(1'b0, 1'b0, 8'h00, 6'h00);
        dstep(1'b0, 1'b1, 8'h00, 6'h00);
        dstep(1'b0, 1'b0, 8'h00, 6'h00);
        dstep(1'b1, 1'b0, 8'h41, 6'h10);
        dstep(1'b1, 1'b0, 8'h41, 6'h10);
        dstep(1'b0, 1'b0, 8'h41, 6'h00);
        dstep(1'b1, 1'b0, 8'h41, 6'h10);
        dstep(1'b1, 1'b0, 8'h41, 6'h11);
        dstep(1'b0, 1'b0, 8'h00, 6'h00);
        dstep(1'b1, 1'b0, 8'hFF, 6'h3F);
        dstep(1'b1, 1'b0, 8'hFF, 6'h3F);
        dstep(1'b0, 1'b0, 8'hFF, 6'h00);
        dstep(1'b1, 1'b0, 8'hFF, 6'h3F);
        dstep(1'b1, 1'b0, 8'hFF, 6'h3F);
        dstep(1'b0, 1'b0, 8'h00, 6'h00);
        dstep(1'b0, 1'b0, 8'h00, 6'h00);

        // Resolution measurement; the long line is the last of the frame.
        pulse_reset();
        red_in = 8'h55; green_in = 8'h55; blue_in = 8'h55;
        do_frame(3, 2, 2, 1'b0);
        do_vsync();
        check("meas_first_valid", m0_mv, 1'b0);
        check("meas_first_hv", {m0_h, m0_v}, {12'd2, 12'd3});
        do_frame(480, 2, 640, 1'b0);
        check("meas_before_2nd", m0_mv, 1'b0);
        do_vsync();
        check("meas_h_640", m0_h, 12'd640);
        check("meas_v_480", m0_v, 12'd480);
        check("meas_valid_2nd", m0_mv, 1'b1);
        // Last DE fall lands in the same cycle as the vsync rise.
        do_frame(100, 7, 7, 1'b1);
        tick();
        check("meas_coincident", {m0_h, m0_v, m0_mv}, {12'd7, 12'd100, 1'b1});

        // Asynchronous reset in the middle of an active line.
        de_in = 1'b1; red_in = 8'hB7; green_in = 8'hB7; blue_in = 8'hB7;
        tick(); tick(); tick();
        check("pre_reset_red", {m0_de, m0_r}, {1'b1, 6'h2D});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {m0_hs, m0_vs, m0_de, m0_r, m0_g, m0_b, m0_h, m0_v, m0_mv}, 64'd0);
        de_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_frame(5, 4, 4, 1'b0);
        do_vsync();
        check("restart_1st_vsync", m0_mv, 1'b0);
        do_frame(5, 4, 4, 1'b0);
        do_vsync();
        check("restart_2nd_vsync", {m0_h, m0_v, m0_mv}, {12'd4, 12'd5, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
